cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-port arbiter that shares the SoC's single main-memory port between the instruction cache and the data cache. Sits inside the SoC between the I-/D-cache refill/write-back interfaces and the memory-mapped main memory. Grants one single-word transaction at a time, using round-robin order on contention. Includes a transaction timeout so a hung memory or peripheral cannot stall either cache forever.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; must be a multiple of 8
- TIMEOUT_CYCLES, 255, maximum cycles from m_req rise to m_ack; 0 disables the timeout

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-cache read request; held high until i_ack
- i_addr  in  ADDR_WIDTH  I-cache word address
- i_rdata  out  DATA_WIDTH  read data; valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  qualifies i_ack; 1 = timed out
- d_req  in  1  D-cache request; held high until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  D-cache address
- d_wdata  in  DATA_WIDTH  write data
- d_wstrb  in  DATA_WIDTH/8  byte enables
- d_rdata  out  DATA_WIDTH  read data; valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  qualifies d_ack; 1 = timed out
- m_req  out  1  memory request; held until m_ack
- m_we, m_addr, m_wdata, m_wstrb  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  memory command, stable while m_req=1
- m_rdata  in  DATA_WIDTH  memory read data, sampled when m_ack=1
- m_ack  in  1  memory completion pulse
- grant_d  out  1  1 while the D-cache owns the port; for debug and performance counters

## Operation
- The FSM has four states: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE, arbitration on the sampled requests:
  - Only i_req high -> GRANT_I.
  - Only d_req high -> GRANT_D.
  - Both high -> grant the port not granted last (last_grant register).
  - Neither high -> stay in IDLE.
- On the grant edge:
  - Latch the winner's command into the m_* registers. For I grants: m_we=0, m_wstrb=0, m_wdata=0.
  - Update last_grant and clear the timeout counter.
- GRANT_x:
  - m_req=1 and the command stays stable.
  - On m_ack: capture m_rdata into x_rdata (writes capture it too; the value is don't-care) and go to RESP with err=0.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without m_ack: go to RESP with err=1 and x_rdata=0.
- RESP:
  - Pulse x_ack=1 for exactly one cycle, with x_err and x_rdata valid; m_req=0.
  - Then go to IDLE.
  - No arbitration is done in RESP.
- Requester rule: drop x_req on the edge after x_ack is seen. The RESP cycle guarantees the dropped request is not re-granted.
- m_ack outside GRANT_x is ignored. A late m_ack that arrives after a timeout is discarded.
- Requests and their payloads are not latched until the grant edge. The requester must hold them stable while x_req=1.
- A fixed priority of either cache is forbidden. Under continuous contention, grants alternate I, D, I, D.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - State = IDLE, last_grant = D, so I wins the first tie.
  - All outputs are 0: m_req, m_we, m_addr, m_wdata, m_wstrb, i_/d_rdata, i_/d_ack, i_/d_err, grant_d.
  - The timeout counter is 0.
- All outputs are registered. No combinational path exists from any input to any output.
- Minimum latency:
  - x_req high in IDLE at edge 0.
  - m_req high from cycle 1.
  - m_ack seen in cycle 1 -> x_ack in cycle 2 -> IDLE in cycle 3.
- Best throughput is one transaction per 3 cycles.
- General latency: x_ack is asserted exactly 1 cycle after the cycle where m_ack=1.
- Timeout: err response when the counter equals TIMEOUT_CYCLES, i.e. x_ack in cycle TIMEOUT_CYCLES+2 after the grant edge.
- grant_d is 1 in GRANT_D and in the RESP that follows it, and 0 otherwise.

## Test plan
- Reset → all outputs 0.
  - I read at 0x100 alone, memory acks 1 cycle after m_req with 0xDEADBEEF → i_ack pulse 1 cycle, i_rdata=0xDEADBEEF, i_err=0, 3-cycle turnaround.
- D write at 0x200, data 0x12345678, wstrb 0b0011 → m_we=1, m_wstrb=0b0011, m_wdata stable until m_ack; d_ack pulses once; i_ack stays 0.
- i_req and d_req both held continuously for 6 transactions → grant order I,D,I,D,I,D; each ack matches its own address/data.
- TIMEOUT_CYCLES=8, memory never acks → d_ack=1 and d_err=1 at cycle 10 after grant, d_rdata=0; m_req drops; a spurious m_ack injected afterwards causes no ack.
- Assert rst_n=0 while in GRANT_I with m_req=1 → outputs go to 0 asynchronously; after release, a tie goes to I first and no stale i_ack appears.
- TIMEOUT_CYCLES=0 with a 1000-cycle memory stall → no error; the ack arrives normally after m_ack.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_if
// Description : Bundle of the I-cache, D-cache and main-memory signals that
//               meet at the cache/memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // I-cache side
    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_ack;
    logic                    i_err;

    // D-cache side
    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wstrb;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_ack;
    logic                    d_err;

    // Main-memory side
    logic                    m_req;
    logic                    m_we;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic                    m_ack;

    logic                    grant_d;

    // master: the arbiter, which owns the memory port; slave: the surrounding system
    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ack, d_err,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ack,
        output grant_d
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ack, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ack,
        input  grant_d
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Round-robin arbiter sharing one single-word main-memory port
//               between the I-cache and D-cache, with transaction timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_mem_arbiter_if.master bus
);

    localparam int c_STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_last_d;
    logic                    r_m_req;
    logic                    r_m_we;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [DATA_WIDTH-1:0]   r_m_wdata;
    logic [c_STRB_W-1:0]     r_m_wstrb;
    logic [DATA_WIDTH-1:0]   r_i_rdata;
    logic                    r_i_ack;
    logic                    r_i_err;
    logic [DATA_WIDTH-1:0]   r_d_rdata;
    logic                    r_d_ack;
    logic                    r_d_err;
    logic                    r_grant_d;

    logic                    w_in_grant;
    logic                    w_pick_d;
    logic                    w_timeout;

    assign w_in_grant = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);

    // On a tie the port goes to whichever cache was not served last
    assign w_pick_d = bus.d_req && (!bus.i_req || !r_last_d);

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout
            localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_in_grant && (r_cnt != c_LIMIT)) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_timeout = w_in_grant && (r_cnt == c_LIMIT);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b1;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
            r_i_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_rdata <= '0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_grant_d <= 1'b0;
        end else begin
            // Acks and errors are single-cycle pulses valid only in RESP
            r_i_ack <= 1'b0;
            r_i_err <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        r_m_req   <= 1'b1;
                        r_grant_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        if (w_pick_d) begin
                            r_m_we    <= bus.d_we;
                            r_m_addr  <= bus.d_addr;
                            r_m_wdata <= bus.d_wdata;
                            r_m_wstrb <= bus.d_wstrb;
                            r_state   <= S_GRANT_D;
                        end else begin
                            r_m_we    <= 1'b0;
                            r_m_addr  <= bus.i_addr;
                            r_m_wdata <= '0;
                            r_m_wstrb <= '0;
                            r_state   <= S_GRANT_I;
                        end
                    end
                end

                S_GRANT_I: begin
                    if (bus.m_ack) begin
                        r_i_rdata <= bus.m_rdata;
                        r_i_ack   <= 1'b1;
                        r_m_req   <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_timeout) begin
                        r_i_rdata <= '0;
                        r_i_ack   <= 1'b1;
                        r_i_err   <= 1'b1;
                        r_m_req   <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end

                S_GRANT_D: begin
                    if (bus.m_ack) begin
                        r_d_rdata <= bus.m_rdata;
                        r_d_ack   <= 1'b1;
                        r_m_req   <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_timeout) begin
                        r_d_rdata <= '0;
                        r_d_ack   <= 1'b1;
                        r_d_err   <= 1'b1;
                        r_m_req   <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Gap cycle lets the requester drop its request before re-arbitration
                    r_grant_d <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_wstrb = r_m_wstrb;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_ack   = r_i_ack;
    assign bus.i_err   = r_i_err;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_ack   = r_d_ack;
    assign bus.d_err   = r_d_err;
    assign bus.grant_d = r_grant_d;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed self-checking bench for cache_mem_arbiter, with one
//               instance using an 8-cycle timeout and one with it disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    cache_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    cache_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    cache_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    cache_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out_a();
        return |{bus_a.m_req, bus_a.m_we, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb,
                 bus_a.i_rdata, bus_a.i_ack, bus_a.i_err,
                 bus_a.d_rdata, bus_a.d_ack, bus_a.d_err, bus_a.grant_d};
    endfunction

    function automatic logic any_out_b();
        return |{bus_b.m_req, bus_b.m_we, bus_b.m_addr, bus_b.m_wdata, bus_b.m_wstrb,
                 bus_b.i_rdata, bus_b.i_ack, bus_b.i_err,
                 bus_b.d_rdata, bus_b.d_ack, bus_b.d_err, bus_b.grant_d};
    endfunction

    initial begin
        logic        seen;
        logic [31:0] exp_addr;
        logic        exp_d;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_a.i_req = 1'b0; bus_a.i_addr = '0;
        bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_addr = '0;
        bus_a.d_wdata = '0; bus_a.d_wstrb = '0;
        bus_a.m_rdata = '0; bus_a.m_ack = 1'b0;
        bus_b.i_req = 1'b0; bus_b.i_addr = '0;
        bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_addr = '0;
        bus_b.d_wdata = '0; bus_b.d_wstrb = '0;
        bus_b.m_rdata = '0; bus_b.m_ack = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("reset_outputs_a", 32'(any_out_a()), 32'd0);
        chk("reset_outputs_b", 32'(any_out_b()), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- lone I read, 1-cycle memory ----------------
        bus_a.i_req  = 1'b1;
        bus_a.i_addr = 32'h0000_0100;
        tick();
        chk("i_read_m_req",   32'(bus_a.m_req),   32'd1);
        chk("i_read_m_addr",  bus_a.m_addr,       32'h0000_0100);
        chk("i_read_m_we",    32'(bus_a.m_we),    32'd0);
        chk("i_read_grant_d", 32'(bus_a.grant_d), 32'd0);
        bus_a.m_ack   = 1'b1;
        bus_a.m_rdata = 32'hDEAD_BEEF;
        tick();
        bus_a.m_ack = 1'b0;
        chk("i_read_ack",   32'(bus_a.i_ack), 32'd1);
        chk("i_read_rdata", bus_a.i_rdata,    32'hDEAD_BEEF);
        chk("i_read_err",   32'(bus_a.i_err), 32'd0);
        chk("i_read_mreq_dropped", 32'(bus_a.m_req), 32'd0);
        bus_a.i_req = 1'b0;
        tick();
        chk("i_read_ack_one_cycle", 32'(bus_a.i_ack), 32'd0);

        // ---------------- lone D write ----------------
        bus_a.d_req   = 1'b1;
        bus_a.d_we    = 1'b1;
        bus_a.d_addr  = 32'h0000_0200;
        bus_a.d_wdata = 32'h1234_5678;
        bus_a.d_wstrb = 4'b0011;
        tick();
        chk("d_write_m_we",    32'(bus_a.m_we),    32'd1);
        chk("d_write_m_wstrb", 32'(bus_a.m_wstrb), 32'h3);
        chk("d_write_m_wdata", bus_a.m_wdata,      32'h1234_5678);
        chk("d_write_m_addr",  bus_a.m_addr,       32'h0000_0200);
        chk("d_write_grant_d", 32'(bus_a.grant_d), 32'd1);
        tick();
        tick();
        chk("d_write_wdata_stable", bus_a.m_wdata,   32'h1234_5678);
        chk("d_write_mreq_held",    32'(bus_a.m_req), 32'd1);
        bus_a.m_ack   = 1'b1;
        bus_a.m_rdata = 32'h0000_0000;
        tick();
        bus_a.m_ack = 1'b0;
        chk("d_write_ack",        32'(bus_a.d_ack),   32'd1);
        chk("d_write_err",        32'(bus_a.d_err),   32'd0);
        chk("d_write_no_i_ack",   32'(bus_a.i_ack),   32'd0);
        chk("d_write_grant_resp", 32'(bus_a.grant_d), 32'd1);
        bus_a.d_req = 1'b0;
        bus_a.d_we  = 1'b0;
        tick();
        chk("d_write_ack_one_cycle", 32'(bus_a.d_ack),   32'd0);
        chk("d_write_grant_cleared", 32'(bus_a.grant_d), 32'd0);

        // ---------------- continuous contention: I,D,I,D,I,D ----------------
        bus_a.i_req  = 1'b1;
        bus_a.i_addr = 32'h0000_1000;
        bus_a.d_req  = 1'b1;
        bus_a.d_we   = 1'b0;
        bus_a.d_addr = 32'h0000_2000;
        for (int k = 0; k < 6; k++) begin
            exp_d    = k[0];
            exp_addr = exp_d ? 32'h0000_2000 + 32'(4 * (k / 2))
                             : 32'h0000_1000 + 32'(4 * (k / 2));
            tick();
            chk($sformatf("rr_grant_d_%0d", k), 32'(bus_a.grant_d), 32'(exp_d));
            chk($sformatf("rr_m_addr_%0d", k),  bus_a.m_addr,       exp_addr);
            bus_a.m_ack   = 1'b1;
            bus_a.m_rdata = 32'hA5A5_0000 + 32'(k);
            tick();
            bus_a.m_ack = 1'b0;
            if (exp_d) begin
                chk($sformatf("rr_d_ack_%0d", k),   32'(bus_a.d_ack), 32'd1);
                chk($sformatf("rr_i_quiet_%0d", k), 32'(bus_a.i_ack), 32'd0);
                chk($sformatf("rr_d_rdata_%0d", k), bus_a.d_rdata,    32'hA5A5_0000 + 32'(k));
                bus_a.d_addr = 32'h0000_2000 + 32'(4 * (k / 2 + 1));
            end else begin
                chk($sformatf("rr_i_ack_%0d", k),   32'(bus_a.i_ack), 32'd1);
                chk($sformatf("rr_d_quiet_%0d", k), 32'(bus_a.d_ack), 32'd0);
                chk($sformatf("rr_i_rdata_%0d", k), bus_a.i_rdata,    32'hA5A5_0000 + 32'(k));
                bus_a.i_addr = 32'h0000_1000 + 32'(4 * (k / 2 + 1));
            end
            if (k == 5) begin
                bus_a.i_req = 1'b0;
                bus_a.d_req = 1'b0;
            end
            tick();
        end

        // ---------------- timeout (8 cycles), memory never acks ----------------
        bus_a.d_req  = 1'b1;
        bus_a.d_we   = 1'b0;
        bus_a.d_addr = 32'h0000_0300;
        tick();
        seen = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (bus_a.d_ack || !bus_a.m_req) seen = 1'b1;
        end
        chk("timeout_no_early_ack", 32'(seen), 32'd0);
        tick();
        chk("timeout_d_ack",   32'(bus_a.d_ack), 32'd1);
        chk("timeout_d_err",   32'(bus_a.d_err), 32'd1);
        chk("timeout_d_rdata", bus_a.d_rdata,    32'd0);
        chk("timeout_m_req",   32'(bus_a.m_req), 32'd0);
        bus_a.d_req = 1'b0;
        tick();
        bus_a.m_ack   = 1'b1;
        bus_a.m_rdata = 32'h5555_AAAA;
        tick();
        bus_a.m_ack = 1'b0;
        tick();
        chk("late_ack_no_d_ack", 32'(bus_a.d_ack), 32'd0);
        chk("late_ack_no_i_ack", 32'(bus_a.i_ack), 32'd0);
        chk("late_ack_idle",     32'(bus_a.m_req), 32'd0);

        // ---------------- async reset mid-transaction ----------------
        bus_a.i_req  = 1'b1;
        bus_a.i_addr = 32'h0000_0400;
        tick();
        chk("pre_reset_m_req", 32'(bus_a.m_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(any_out_a()), 32'd0);
        bus_a.d_req  = 1'b1;
        bus_a.d_addr = 32'h0000_0500;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_tie_to_i", 32'(bus_a.grant_d), 32'd0);
        chk("post_reset_m_addr",   bus_a.m_addr,       32'h0000_0400);
        chk("post_reset_no_stale", 32'(bus_a.i_ack),   32'd0);
        bus_a.m_ack   = 1'b1;
        bus_a.m_rdata = 32'h0BAD_CAFE;
        tick();
        bus_a.m_ack = 1'b0;
        chk("post_reset_i_ack",   32'(bus_a.i_ack), 32'd1);
        chk("post_reset_i_rdata", bus_a.i_rdata,    32'h0BAD_CAFE);
        bus_a.i_req = 1'b0;
        tick();
        tick();
        chk("post_reset_d_grant", 32'(bus_a.grant_d), 32'd1);
        chk("post_reset_d_addr",  bus_a.m_addr,       32'h0000_0500);
        bus_a.m_ack = 1'b1;
        tick();
        bus_a.m_ack = 1'b0;
        chk("post_reset_d_ack", 32'(bus_a.d_ack), 32'd1);
        bus_a.d_req = 1'b0;
        tick();

        // ---------------- timeout disabled, 1000-cycle stall ----------------
        bus_b.d_req  = 1'b1;
        bus_b.d_we   = 1'b0;
        bus_b.d_addr = 32'h0000_0600;
        tick();
        chk("stall_grant", 32'(bus_b.grant_d), 32'd1);
        seen = 1'b0;
        repeat (1000) begin
            tick();
            if (bus_b.d_ack || bus_b.d_err) seen = 1'b1;
        end
        chk("stall_no_response", 32'(seen),        32'd0);
        chk("stall_m_req_held",  32'(bus_b.m_req), 32'd1);
        bus_b.m_ack   = 1'b1;
        bus_b.m_rdata = 32'hCAFE_F00D;
        tick();
        bus_b.m_ack = 1'b0;
        chk("stall_d_ack",   32'(bus_b.d_ack), 32'd1);
        chk("stall_d_err",   32'(bus_b.d_err), 32'd0);
        chk("stall_d_rdata", bus_b.d_rdata,    32'hCAFE_F00D);
        bus_b.d_req = 1'b0;
        tick();
        chk("stall_ack_one_cycle", 32'(bus_b.d_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
